// File: rtl/complex_addsub_pipe_if.sv
// Handshake/data bundle for complex_addsub_pipe.
//   in_valid/in_ready : input beat handshake
//   a, b              : operands {real[2W-1:W], imag[W-1:0]}, signed
//   mode              : 00 A+B, 01 A-B, 10 A-jB, 11 A+jB, sampled with the beat
//   out_valid/out_ready : result beat handshake
//   r                 : result {real, imag}
//   c_out             : raw adder carry-out {real, imag}; 1 = no borrow on subtract legs
//   ovf               : signed overflow {real, imag}, before saturation
// slave is the unit's view, master is the producer/consumer's view.
interface complex_addsub_pipe_if #(
  parameter int unsigned W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] a;
  logic [2*W-1:0] b;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] r;
  logic [1:0]     c_out;
  logic [1:0]     ovf;

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, r, c_out, ovf
  );

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, r, c_out, ovf
  );
endinterface

// File: rtl/complex_addsub_pipe.sv
// Pipelined complex add/subtract unit for the FFT datapath.
// Computes A+B, A-B, A-jB or A+jB per beat with per-component carry, signed
// overflow and optional saturation. LAT register stages with full backpressure.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : complex_addsub_pipe_if.slave (handshakes, operands, mode, results)
module complex_addsub_pipe #(
  parameter int unsigned W   = 16,
  parameter int unsigned LAT = 2,   // legal 1..4
  parameter int unsigned SAT = 0    // 1 = clamp on signed overflow
) (
  input logic                   clk,
  input logic                   rst,
  complex_addsub_pipe_if.slave  bus
);

  // Returns {carry, ovf, result}. Subtract is x + ~y + 1.
  function automatic logic [W+1:0] addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
    logic [W-1:0] yy;
    logic [W:0]   sum;
    logic         o;
    logic [W-1:0] res;
    yy  = sub ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sub};
    o   = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
    res = sum[W-1:0];
    if ((SAT != 0) && o) begin
      // Operand sign tells the overflow direction.
      res = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return {sum[W], o, res};
  endfunction

  logic [W-1:0] ar, ai, br, bi;
  logic [W-1:0] r_y, i_y;
  logic         r_sub, i_sub;
  logic [W+1:0] r_res, i_res;

  assign ar = bus.a[2*W-1:W];
  assign ai = bus.a[W-1:0];
  assign br = bus.b[2*W-1:W];
  assign bi = bus.b[W-1:0];

  always_comb begin
    r_y   = br;
    i_y   = bi;
    r_sub = 1'b0;
    i_sub = 1'b0;
    case (bus.mode)
      2'b01: begin
        r_sub = 1'b1;
        i_sub = 1'b1;
      end
      2'b10: begin   // A - jB: r = ar + bi, i = ai - br
        r_y   = bi;
        i_y   = br;
        i_sub = 1'b1;
      end
      2'b11: begin   // A + jB: r = ar - bi, i = ai + br
        r_y   = bi;
        i_y   = br;
        r_sub = 1'b1;
      end
      default: ;
    endcase
    r_res = addsub(ar, r_y, r_sub);
    i_res = addsub(ai, i_y, i_sub);
  end

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] adv;
  logic [2*W-1:0] r_q [LAT];
  logic [1:0]     c_q [LAT];
  logic [1:0]     o_q [LAT];

  // A stage advances if it or any stage downstream of it is empty, or the sink is ready.
  always_comb begin
    logic ok;
    ok  = bus.out_ready;
    adv = '0;
    for (int i = int'(LAT) - 1; i >= 0; i--) begin
      ok     = ok | ~valid_q[i];
      adv[i] = ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LAT); i++) begin
        r_q[i] <= '0;
        c_q[i] <= '0;
        o_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_q[0] <= bus.in_valid;
        // Data only loads with a real beat so r holds its last value across bubbles.
        if (bus.in_valid) begin
          r_q[0] <= {r_res[W-1:0], i_res[W-1:0]};
          c_q[0] <= {r_res[W+1], i_res[W+1]};
          o_q[0] <= {r_res[W], i_res[W]};
        end
      end
      for (int i = 1; i < int'(LAT); i++) begin
        if (adv[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            r_q[i] <= r_q[i-1];
            c_q[i] <= c_q[i-1];
            o_q[i] <= o_q[i-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[LAT-1];
  assign bus.r         = r_q[LAT-1];
  assign bus.c_out     = c_q[LAT-1];
  assign bus.ovf       = o_q[LAT-1];

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Bench for complex_addsub_pipe: a wrapping and a saturating instance share stimulus;
// expected results are queued on input handshakes and compared on output handshakes.
module tb_complex_addsub_pipe;
  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  typedef struct packed {
    logic [2*W-1:0] r_wrap;
    logic [2*W-1:0] r_sat;
    logic [1:0]     c;
    logic [1:0]     o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_addsub_pipe_if #(.W(W)) dif ();
  complex_addsub_pipe_if #(.W(W)) sif ();

  assign sif.in_valid  = dif.in_valid;
  assign sif.a         = dif.a;
  assign sif.b         = dif.b;
  assign sif.mode      = dif.mode;
  assign sif.out_ready = dif.out_ready;

  complex_addsub_pipe #(.W(W), .LAT(LAT), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(dif));
  complex_addsub_pipe #(.W(W), .LAT(LAT), .SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(sif));

  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  int   stalls = 0;
  int   cyc    = 0;
  int   pop_times [$];
  exp_t q [$];
  exp_t e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One component, done with plain signed integer arithmetic.
  function automatic void leg(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub,
                              output logic [W-1:0] rw, output logic [W-1:0] rs,
                              output logic c, output logic o);
    int sx, sy, ux, uy, t;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = {16'b0, x};
    uy = {16'b0, y};
    t  = sub ? sx - sy : sx + sy;
    o  = (t > MAXV) || (t < MINV);
    c  = sub ? (ux >= uy) : ((ux + uy) >= (1 << W));
    rw = t[W-1:0];
    rs = o ? ((t > 0) ? 16'h7FFF : 16'h8000) : t[W-1:0];
  endfunction

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                 input logic [1:0] m);
    exp_t x;
    logic [W-1:0] rw, rs, iw, is;
    logic rc, ic, ro, io;
    // real leg pairs with bi for the j legs, imag leg with br
    leg(a[2*W-1:W], m[1] ? b[W-1:0] : b[2*W-1:W], (m == 2'b01) || (m == 2'b11), rw, rs, rc, ro);
    leg(a[W-1:0], m[1] ? b[2*W-1:W] : b[W-1:0], (m == 2'b01) || (m == 2'b10), iw, is, ic, io);
    x.r_wrap = {rw, iw};
    x.r_sat  = {rs, is};
    x.c      = {rc, ic};
    x.o      = {ro, io};
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: handshakes observed mid-cycle complete on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.in_valid && dif.in_ready) q.push_back(model(dif.a, dif.b, dif.mode));
      if (dif.out_valid && dif.out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("r_wrap", dif.r, e.r_wrap);
          check("c_wrap", dif.c_out, e.c);
          check("ovf_wrap", dif.ovf, e.o);
          check("valid_sat", sif.out_valid, 1);
          check("r_sat", sif.r, e.r_sat);
          check("c_sat", sif.c_out, e.c);
          check("ovf_sat", sif.ovf, e.o);
        end
        pops++;
        pop_times.push_back(cyc);
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic send(input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic [1:0] m);
    int n;
    n = 0;
    dif.a = a;
    dif.b = b;
    dif.mode = m;
    dif.in_valid = 1'b1;
    @(negedge clk);
    if (!dif.in_ready) stalls++;
    while (!dif.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dif.in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic check_direct(input logic [2*W-1:0] rw, input logic [2*W-1:0] rs,
                              input logic [1:0] c, input logic [1:0] o);
    @(negedge clk);
    check("lat_early", dif.out_valid, 0);
    @(negedge clk);
    check("lat_valid", dif.out_valid, 1);
    check("dir_r_wrap", dif.r, rw);
    check("dir_r_sat", sif.r, rs);
    check("dir_c", dif.c_out, c);
    check("dir_ovf", dif.ovf, o);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || dif.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 200, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   p0;
    logic [2*W-1:0] held;
    logic [1:0] held_c;
    bit   done;
    rst = 1'b1;
    dif.in_valid = 1'b0;
    dif.a = '0;
    dif.b = '0;
    dif.mode = 2'b00;
    dif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", dif.out_valid, 0);
    check("rst_r", dif.r, 0);
    check("rst_c", dif.c_out, 0);
    check("rst_ovf", dif.ovf, 0);
    check("rst_in_ready", dif.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed legs
    send(32'h0005_0010, 32'h0003_0020, 2'b01);
    check_direct(32'h0002_FFF0, 32'h0002_FFF0, 2'b10, 2'b00);
    send(32'h7FFF_8000, 32'h0001_FFFF, 2'b00);
    check_direct(32'h8000_7FFF, 32'h7FFF_8000, 2'b01, 2'b11);
    send(32'h0100_0200, 32'h0010_0020, 2'b10);
    check_direct(32'h0120_01F0, 32'h0120_01F0, 2'b01, 2'b00);
    send(32'h0100_0200, 32'h0010_0020, 2'b11);
    check_direct(32'h00E0_0210, 32'h00E0_0210, 2'b10, 2'b00);

    // Back-to-back stream
    p0 = pops;
    stalls = 0;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 2'(i));
    wait_drain();
    check("stream_stalls", stalls, 0);
    check("stream_count", pops - p0, 8);
    check("stream_consec", pop_times[pop_times.size()-1] - pop_times[pop_times.size()-8], 7);

    // Stall with 6 beats
    p0 = pops;
    dif.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 2'(i + 1));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!dif.out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("stall_wait", dif.out_valid, 1);
        held   = dif.r;
        held_c = dif.c_out;
        repeat (5) begin
          @(negedge clk);
          check("stall_r", dif.r, held);
          check("stall_c", dif.c_out, held_c);
          check("stall_in_ready", dif.in_ready, 0);
          check("stall_valid", dif.out_valid, 1);
        end
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count", pops - p0, 6);

    // Reset with two beats in flight
    dif.out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_2222, 2'b00);
    send(32'h4321_8765, 32'h0101_0202, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("flush_valid", dif.out_valid, 0);
    check("flush_r", dif.r, 0);
    check("flush_in_ready", dif.in_ready, 1);
    check("flush_ovf", dif.ovf, 0);
    @(posedge clk);
    #1;
    dif.out_ready = 1'b1;
    p0 = pops;
    send(32'h8000_7FFF, 32'h0001_8000, 2'b11);
    wait_drain();
    check("flush_single", pops - p0, 1);

    // Random beats under random backpressure
    p0 = pops;
    done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send((i % 4 == 0) ? 32'h8000_7FFF : $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          dif.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    dif.out_ready = 1'b1;
    wait_drain();
    check("rand_count", pops - p0, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/complex_addsub_pipe.md
Name: complex_addsub_pipe

Overview:
Parametrised, pipelined complex add/subtract unit for the FFT datapath; successor to the fixed 32-bit complex KSA subtractor. Per-beat MODE selects A+B, A−B, A−jB or A+jB (radix-4 twiddle-free butterfly legs). Carries, signed-overflow flags and optional saturation are produced per component. Ready/valid handshake on both sides with full backpressure.

Parameters:
W, 16, width of each component (real, imag); total operand width 2*W
LAT, 2, pipeline depth in register stages, legal 1..4
SAT, 0, 1 = clamp on signed overflow, 0 = wrap (two's complement)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
IN_VALID  in  1  input beat valid
IN_READY  out  1  unit can accept a beat this cycle
A  in  2*W  operand A, {real[2W-1:W], imag[W-1:0]}, signed
B  in  2*W  operand B, same packing
MODE  in  2  00 A+B, 01 A−B, 10 A−jB, 11 A+jB; sampled with the beat
OUT_VALID  out  1  result beat valid
OUT_READY  in  1  downstream accepts result
R  out  2*W  result, {real, imag}
C_OUT  out  2  raw adder carry-out {real, imag}; for subtract legs 1 = no borrow
OVF  out  2  signed overflow {real, imag}, before saturation

Behaviour:
- Reset (RST=1 at rising edge): all stage valid bits 0. OUT_VALID=0, R=0, C_OUT=0, OVF=0. IN_READY=1 in the first cycle after reset. Reset mid-operation discards all in-flight beats; no partial output.
- Accept: a beat transfers on an edge where IN_VALID & IN_READY. Output transfers on an edge where OUT_VALID & OUT_READY.
- Per-leg operands: MODE 00: r=ar+br, i=ai+bi. 01: r=ar−br, i=ai−bi. 10: r=ar+bi, i=ai−br. 11: r=ar−bi, i=ai+br.
- Subtraction is computed as x + ~y + 1 at W bits. C_OUT is bit W of that W+1-bit sum. Addition: C_OUT is bit W of x+y.
- OVF=1 when operand signs match (after inversion for subtract) and the result sign differs.
- SAT=1 with OVF: positive overflow → 2^(W-1)−1, negative → −2^(W-1). SAT=0: wrapped W-bit result.
- Arithmetic is done in stage 1. Stages 2..LAT carry R/C_OUT/OVF unchanged.
- Each stage holds a valid bit. A stage advances when it is empty or when the next stage advances; the last stage advances on OUT_READY.
- IN_READY = !valid[1] | advance[1]. It is combinational from OUT_READY through the chain (no skid buffer).
- Latency with no stall: a beat accepted on edge n is presented (OUT_VALID=1) after edge n+LAT−1. Throughput is 1 beat/cycle.
- Stall: while OUT_VALID & !OUT_READY, R/C_OUT/OVF and all full stages hold stable. Bubbles ahead of a stalled stage still compress.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Simultaneous accept and present on the same edge is legal at full throughput.
- Outputs are don't-care when OUT_VALID=0, but R is held at its last value (not X) after reset.

Test Plan:
1. W=16, LAT=2, MODE=01, A={0x0005,0x0010}, B={0x0003,0x0020}, OUT_READY=1 → one cycle after the accepting edge, R={0x0002,0xFFF0}, C_OUT=2'b10, OVF=2'b00.
2. MODE=00, A={0x7FFF,0x8000}, B={0x0001,0xFFFF}: SAT=0 → R={0x8000,0x7FFF}, OVF=2'b11. SAT=1 → R={0x7FFF,0x8000}, OVF=2'b11.
3. MODE=10, A={0x0100,0x0200}, B={0x0010,0x0020} → R={0x0120,0x01F0}. MODE=11, same A and B → R={0x00E0,0x0210}.
4. Stream 8 beats back-to-back with OUT_READY=1 → 8 consecutive OUT_VALID cycles, in order, IN_READY constantly 1.
5. Stream 6 beats; hold OUT_READY=0 for 5 cycles → IN_READY falls after LAT beats are buffered, R stable during the stall. Release → remaining beats drain in order, none lost.
6. Assert RST with 2 beats in flight → next cycle OUT_VALID=0, R=0, IN_READY=1. A subsequent beat emerges alone with the correct result.
